button_conditioner: RTL and testbench

//   Front end for the alarm-clock push-buttons. Turns raw, bouncing, asynchronous

---
 rtl/button_conditioner.sv | 122 ++++++++++++
 tb/tb_button_conditioner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - push-button synchroniser, debouncer, press pulse and hold-to-repeat
//
// Each button is handled by its own independent slice: a two-flop synchroniser,
// a stable-count debouncer, and a small repeat FSM that issues extra pulses
// while an auto-repeat button is held down.

module button_conditioner #(
  parameter int              N_BTN       = 5,
  parameter int              DB_CYCLES   = 500000,
  parameter int              HOLD_CYCLES = 50000000,
  parameter int              RPT_CYCLES  = 10000000,
  parameter logic [N_BTN-1:0] RPT_MASK   = 5'b00110
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam int DBW   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int RMAX  = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int RW    = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [RW-1:0]  HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0]  RPT_LAST  = RW'(RPT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } rpt_state_t;

  genvar gi;
  for (gi = 0; gi < N_BTN; gi++) begin : g_btn
    logic           r_s1;
    logic           r_s2;
    logic           r_level;
    logic [DBW-1:0] r_db_cnt;
    rpt_state_t     r_state;
    logic [RW-1:0]  r_rpt_cnt;
    logic           r_pulse;
    logic           w_accept;
    logic           w_press;

    // The synchronised level has differed from the stable one long enough.
    assign w_accept = (r_s2 != r_level) && (r_db_cnt == DB_LAST);
    assign w_press  = w_accept && r_s2;

    // Synchronise the raw input and accept a new level only after it has been stable.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s1     <= 1'b0;
        r_s2     <= 1'b0;
        r_level  <= 1'b0;
        r_db_cnt <= '0;
      end else begin
        r_s1 <= btn_raw[gi];
        r_s2 <= r_s1;
        if (r_s2 == r_level) begin
          r_db_cnt <= '0;
        end else if (w_accept) begin
          r_level  <= r_s2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end
    end

    // Press pulse plus hold-to-repeat FSM; a release always cancels a due repeat.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state   <= ST_IDLE;
        r_rpt_cnt <= '0;
        r_pulse   <= 1'b0;
      end else begin
        r_pulse <= w_press;
        case (r_state)
          ST_IDLE: begin
            if (RPT_MASK[gi] && w_press) begin
              r_state   <= ST_HOLD;
              r_rpt_cnt <= '0;
            end
          end
          ST_HOLD: begin
            if (!r_level) begin
              r_state   <= ST_IDLE;
              r_rpt_cnt <= '0;
            end else if (r_rpt_cnt == HOLD_LAST) begin
              r_pulse   <= 1'b1;
              r_state   <= ST_REPEAT;
              r_rpt_cnt <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (!r_level) begin
              r_state   <= ST_IDLE;
              r_rpt_cnt <= '0;
            end else if (r_rpt_cnt == RPT_LAST) begin
              r_pulse   <= 1'b1;
              r_rpt_cnt <= '0;
            end else begin
              r_rpt_cnt <= r_rpt_cnt + RW'(1);
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_rpt_cnt <= '0;
          end
        endcase
      end
    end

    assign btn_level[gi] = r_level;
    assign btn_pulse[gi] = r_pulse;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner

module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [4:0] btn_raw;
  logic [4:0] btn_level;
  logic [4:0] btn_pulse;

  int checks;
  int passed;

  typedef struct {
    int         e;
    logic [4:0] m;
  } exp_t;

  exp_t sb[$];

  button_conditioner #(
    .N_BTN      (5),
    .DB_CYCLES  (4),
    .HOLD_CYCLES(10),
    .RPT_CYCLES (3),
    .RPT_MASK   (5'b00110)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push_exp(input int e, input logic [4:0] m);
    exp_t x;
    x.e = e;
    x.m = m;
    sb.push_back(x);
  endfunction

  task automatic settle(input int n);
    btn_raw = 5'b00000;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    btn_raw = 5'b11111;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (btn_level !== 5'b00000)
        $display("FAIL reset_level cyc %0d got %b want %b", k, btn_level, 5'b00000);
      else passed++;
      checks++;
      if (btn_pulse !== 5'b00000)
        $display("FAIL reset_pulse cyc %0d got %b want %b", k, btn_pulse, 5'b00000);
      else passed++;
    end
    btn_raw = 5'b00000;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_clean_press();
    logic [4:0] exp_p, exp_l;
    push_exp(6, 5'b01000);
    for (int k = 1; k <= 30; k++) begin
      btn_raw = (k <= 20) ? 5'b01000 : 5'b00000;
      @(posedge clk);
      #1;
      exp_p = 5'b00000;
      if (sb.size() > 0 && sb[0].e == k) begin
        exp_p = sb[0].m;
        void'(sb.pop_front());
      end
      exp_l = (k >= 6 && k < 26) ? 5'b01000 : 5'b00000;
      checks++;
      if (btn_pulse !== exp_p)
        $display("FAIL press_pulse edge %0d got %b want %b", k, btn_pulse, exp_p);
      else passed++;
      checks++;
      if (btn_level !== exp_l)
        $display("FAIL press_level edge %0d got %b want %b", k, btn_level, exp_l);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL press_sb_left got %0d want 0", sb.size());
    else passed++;
    sb.delete();
  endtask

  task automatic test_bounce();
    logic [4:0] exp_p, exp_l;
    push_exp(18, 5'b00001);
    for (int k = 1; k <= 30; k++) begin
      if (k <= 12)      btn_raw = (((k - 1) / 2) % 2 == 0) ? 5'b00001 : 5'b00000;
      else if (k <= 22) btn_raw = 5'b00001;
      else              btn_raw = 5'b00000;
      @(posedge clk);
      #1;
      exp_p = 5'b00000;
      if (sb.size() > 0 && sb[0].e == k) begin
        exp_p = sb[0].m;
        void'(sb.pop_front());
      end
      exp_l = (k >= 18 && k < 28) ? 5'b00001 : 5'b00000;
      checks++;
      if (btn_pulse !== exp_p)
        $display("FAIL bounce_pulse edge %0d got %b want %b", k, btn_pulse, exp_p);
      else passed++;
      checks++;
      if (btn_level !== exp_l)
        $display("FAIL bounce_level edge %0d got %b want %b", k, btn_level, exp_l);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL bounce_sb_left got %0d want 0", sb.size());
    else passed++;
    sb.delete();
  endtask

  task automatic test_repeat();
    logic [4:0] exp_p, exp_l;
    push_exp(6, 5'b01010);
    for (int e = 16; e <= 46; e += 3) push_exp(e, 5'b00010);
    for (int k = 1; k <= 55; k++) begin
      btn_raw = (k <= 41) ? 5'b01010 : 5'b00000;
      @(posedge clk);
      #1;
      exp_p = 5'b00000;
      if (sb.size() > 0 && sb[0].e == k) begin
        exp_p = sb[0].m;
        void'(sb.pop_front());
      end
      exp_l = (k >= 6 && k < 47) ? 5'b01010 : 5'b00000;
      checks++;
      if (btn_pulse !== exp_p)
        $display("FAIL repeat_pulse edge %0d got %b want %b", k, btn_pulse, exp_p);
      else passed++;
      checks++;
      if (btn_level !== exp_l)
        $display("FAIL repeat_level edge %0d got %b want %b", k, btn_level, exp_l);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL repeat_sb_left got %0d want 0", sb.size());
    else passed++;
    sb.delete();
  endtask

  task automatic test_simultaneous();
    logic [4:0] exp_p, exp_l;
    push_exp(6, 5'b10001);
    for (int k = 1; k <= 20; k++) begin
      btn_raw = (k <= 10) ? 5'b10001 : 5'b00000;
      @(posedge clk);
      #1;
      exp_p = 5'b00000;
      if (sb.size() > 0 && sb[0].e == k) begin
        exp_p = sb[0].m;
        void'(sb.pop_front());
      end
      exp_l = (k >= 6 && k < 16) ? 5'b10001 : 5'b00000;
      checks++;
      if (btn_pulse !== exp_p)
        $display("FAIL simul_pulse edge %0d got %b want %b", k, btn_pulse, exp_p);
      else passed++;
      checks++;
      if (btn_level !== exp_l)
        $display("FAIL simul_level edge %0d got %b want %b", k, btn_level, exp_l);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL simul_sb_left got %0d want 0", sb.size());
    else passed++;
    sb.delete();
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] exp_p, exp_l;
    push_exp(6, 5'b00100);
    for (int k = 1; k <= 12; k++) begin
      btn_raw = 5'b00100;
      @(posedge clk);
      #1;
      exp_p = 5'b00000;
      if (sb.size() > 0 && sb[0].e == k) begin
        exp_p = sb[0].m;
        void'(sb.pop_front());
      end
      exp_l = (k >= 6) ? 5'b00100 : 5'b00000;
      checks++;
      if (btn_pulse !== exp_p)
        $display("FAIL midrst_pre_pulse edge %0d got %b want %b", k, btn_pulse, exp_p);
      else passed++;
      checks++;
      if (btn_level !== exp_l)
        $display("FAIL midrst_pre_level edge %0d got %b want %b", k, btn_level, exp_l);
      else passed++;
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (btn_level !== 5'b00000)
      $display("FAIL midrst_async_level got %b want %b", btn_level, 5'b00000);
    else passed++;
    checks++;
    if (btn_pulse !== 5'b00000)
      $display("FAIL midrst_async_pulse got %b want %b", btn_pulse, 5'b00000);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (btn_level !== 5'b00000)
      $display("FAIL midrst_held_level got %b want %b", btn_level, 5'b00000);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    push_exp(6, 5'b00100);
    for (int e = 16; e <= 28; e += 3) push_exp(e, 5'b00100);
    for (int k = 1; k <= 35; k++) begin
      btn_raw = (k <= 23) ? 5'b00100 : 5'b00000;
      @(posedge clk);
      #1;
      exp_p = 5'b00000;
      if (sb.size() > 0 && sb[0].e == k) begin
        exp_p = sb[0].m;
        void'(sb.pop_front());
      end
      exp_l = (k >= 6 && k < 29) ? 5'b00100 : 5'b00000;
      checks++;
      if (btn_pulse !== exp_p)
        $display("FAIL midrst_post_pulse edge %0d got %b want %b", k, btn_pulse, exp_p);
      else passed++;
      checks++;
      if (btn_level !== exp_l)
        $display("FAIL midrst_post_level edge %0d got %b want %b", k, btn_level, exp_l);
      else passed++;
    end
    checks++;
    if (sb.size() != 0) $display("FAIL midrst_sb_left got %0d want 0", sb.size());
    else passed++;
    sb.delete();
  endtask

  initial begin
    checks  = 0;
    passed  = 0;
    rst     = 1'b0;
    btn_raw = 5'b00000;
    test_reset();
    test_clean_press();
    settle(4);
    test_bounce();
    settle(4);
    test_repeat();
    settle(4);
    test_simultaneous();
    settle(4);
    test_reset_mid_hold();
    settle(4);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
